// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam int PC_STEP = 4;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of fetched {instruction, pc} pairs; flush empties it at the edge
// and push+pop in the same cycle is legal even when full.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o,
    output logic          full_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    // A pop frees the head slot this cycle, so a full FIFO can still accept a push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited in-order fetch, prefetch FIFO, redirect/drain.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_redirects counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                DATA_WIDTH = 32,
    parameter int                ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  PCSrc,
    input  logic [DATA_WIDTH-1:0] ImmExt,
    input  logic [ADDR_WIDTH-1:0] branch_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           perf_fetched,
    output logic [31:0]           perf_redirects
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]         outstanding_q, outstanding_d, drop_q, drop_d;

    logic                  redirect, req_fire, push, pop, flush, credit_ok;
    logic [ADDR_WIDTH-1:0] target_sum, target;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty, fifo_full;
    fetch_entry_t          fifo_head, push_entry;

    assign redirect   = PCSrc && (state_q != BOOT);
    assign target_sum = branch_pc + ADDR_WIDTH'(ImmExt);
    assign target     = {target_sum[ADDR_WIDTH-1:2], 2'b00};

    // Buffered plus in-flight words never exceed the FIFO size, so responses always fit.
    assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
    assign imem_req_valid = (state_q == FETCH) && credit_ok;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign pop        = !fifo_empty && instr_ready;
    assign push_entry = '{data: imem_rsp_data, pc: rsp_pc_q};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        push          = 1'b0;
        flush         = 1'b0;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
                if (redirect) begin
                    // Everything still in flight, including a request accepted now, is stale.
                    flush    = 1'b1;
                    pc_d     = target;
                    rsp_pc_d = target;
                    drop_d   = outstanding_d;
                    state_d  = (outstanding_d != '0) ? DRAIN : FETCH;
                end else begin
                    if (req_fire) pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
                    if (imem_rsp_valid) begin
                        push     = 1'b1;
                        rsp_pc_d = rsp_pc_q + ADDR_WIDTH'(PC_STEP);
                    end
                end
            end
            DRAIN: begin
                if (imem_rsp_valid) begin
                    drop_d        = drop_q - CW'(1);
                    outstanding_d = outstanding_q - CW'(1);
                end
                if (redirect) begin
                    flush    = 1'b1;
                    pc_d     = target;
                    rsp_pc_d = target;
                end
                if (drop_d == '0) state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .flush_i (flush),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? INSTR_NOP : fifo_head.data;
    assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;

    overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_redirects_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q   <= '0;
            perf_redirects_q <= '0;
        end else begin
            if (pop)      perf_fetched_q   <= perf_fetched_q + 32'd1;
            if (redirect) perf_redirects_q <= perf_redirects_q + 32'd1;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed sequences, a redirect-target vector table and a
// randomized run against a queue-based reference model with a behavioural memory.
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic        PCSrc;
    logic [31:0] ImmExt, branch_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetched, perfRedirects;
`endif

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .PCSrc          (PCSrc),
        .ImmExt         (ImmExt),
        .branch_pc      (branch_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perfFetched),
        .perf_redirects (perfRedirects)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] data;
        bit [31:0] pc;
    } entry_t;

    typedef struct {
        logic [31:0] bpc;
        logic [31:0] imm;
        logic [31:0] expAddr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    bit [31:0] pendAddr[$];
    int        pendDue[$];
    int        cycleNum = 0;
    bit        memHold = 0;
    bit        randLat = 0;

    // Reference model: mode 0 boot, 1 fetch, 2 drain
    entry_t    mq[$];
    int        mMode = 0;
    int        mInflight = 0;
    bit [31:0] mPc = 0;
    bit [31:0] mRspPc = 0;

    logic        sReqValid, sIvalid;
    logic [31:0] sAddr, sInstr, sIpc;
    int          fireCount = 0;

    function automatic bit [31:0] memWord(input bit [31:0] a);
        if (a == 32'h0) return 32'h0000_0013;
        if (a == 32'h4) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0B13;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One clock cycle: memory answers, outputs compared at negedge, model advanced at posedge.
    task automatic applyStimulus();
        bit        rsp, fire, mFire, pop, redir, expValid;
        bit [31:0] rdata, tgt;
        rsp   = !memHold && pendAddr.size() > 0 && pendDue[0] <= cycleNum;
        rdata = 32'hDEAD_BEEF;
        if (rsp) rdata = memWord(pendAddr[0]);
        imem_rsp_valid = rsp;
        imem_rsp_data  = rdata;
        @(negedge clk);
        sReqValid = imem_req_valid;
        sAddr     = imem_req_addr;
        sIvalid   = instr_valid;
        sInstr    = instr;
        sIpc      = instr_pc;
        expValid  = (mMode == 1) && (mInflight + mq.size() < DEPTH);
        checkOutput("req_valid", 32'(sReqValid), 32'(expValid));
        checkOutput("req_addr", sAddr, mPc);
        checkOutput("instr_valid", 32'(sIvalid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            checkOutput("instr", sInstr, mq[0].data);
            checkOutput("instr_pc", sIpc, mq[0].pc);
        end
        fire = sReqValid && imem_req_ready;
        if (fire) fireCount++;
        @(posedge clk);
        if (rsp) begin
            void'(pendAddr.pop_front());
            void'(pendDue.pop_front());
        end
        if (fire) begin
            pendAddr.push_back(sAddr);
            pendDue.push_back(cycleNum + (randLat ? int'($urandom_range(1, 3)) : 1));
        end
        mFire = expValid && imem_req_ready;
        pop   = mq.size() > 0 && instr_ready;
        redir = PCSrc && mMode != 0;
        tgt   = (branch_pc + ImmExt) & ~32'h3;
        if (mMode == 0) begin
            mMode = 1;
        end else if (redir) begin
            mq.delete();
            mPc    = tgt;
            mRspPc = tgt;
            if (mMode == 1) mInflight = mInflight + int'(mFire) - int'(rsp);
            else            mInflight = mInflight - int'(rsp);
            mMode = (mInflight > 0) ? 2 : 1;
        end else if (mMode == 1) begin
            if (pop) void'(mq.pop_front());
            if (rsp) begin
                mq.push_back('{data: rdata, pc: mRspPc});
                mRspPc = mRspPc + 32'd4;
            end
            if (mFire) mPc = mPc + 32'd4;
            mInflight = mInflight + int'(mFire) - int'(rsp);
            if (mq.size() > DEPTH) checkOutput("model_fifo_bound", 32'(mq.size()), DEPTH);
        end else if (rsp) begin
            mInflight--;
            if (mInflight == 0) mMode = 1;
        end
        cycleNum++;
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'h0);
        checkOutput("rst_req_addr", imem_req_addr, 32'h0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'h0);
        checkOutput("rst_instr", instr, 32'h0000_0013);
        checkOutput("rst_instr_pc", instr_pc, 32'h0);
        imem_rsp_valid = 1'b0;
        PCSrc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        pendAddr.delete();
        pendDue.delete();
        memHold   = 0;
        mq.delete();
        mMode     = 0;
        mInflight = 0;
        mPc       = 32'h0;
        mRspPc    = 32'h0;
        rst_n     = 1'b1;
    endtask

    task automatic setupTwoInFlight();
        doReset();
        memHold = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b0;
        repeat (4) applyStimulus();
        PCSrc = 1'b1;
        branch_pc = 32'h10;
        ImmExt = 32'hFFFF_FFF8;
        applyStimulus();
        PCSrc = 1'b0;
        applyStimulus();
    endtask

    vec_t vecs[5];

    initial begin
        bit found;
        bit [31:0] r;
        vecs[0] = '{bpc: 32'h0000_0100, imm: 32'h0000_0006, expAddr: 32'h0000_0104};
        vecs[1] = '{bpc: 32'h0000_0010, imm: 32'hFFFF_FFF8, expAddr: 32'h0000_0008};
        vecs[2] = '{bpc: 32'hFFFF_FFFC, imm: 32'h0000_0008, expAddr: 32'h0000_0004};
        vecs[3] = '{bpc: 32'h0000_0007, imm: 32'h0000_0000, expAddr: 32'h0000_0004};
        vecs[4] = '{bpc: 32'h0000_1000, imm: 32'hFFFF_F003, expAddr: 32'h0000_0000};

        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        PCSrc = 1'b0;
        ImmExt = '0;
        branch_pc = '0;
        #2;

        $display("[TB] reset release and first fetches");
        doReset();
        applyStimulus();
        checkOutput("boot_no_req", 32'(sReqValid), 32'h0);
        applyStimulus();
        checkOutput("first_req_addr", sAddr, 32'h0);
        applyStimulus();
        checkOutput("second_req_addr", sAddr, 32'h4);
        applyStimulus();
        checkOutput("first_instr", sInstr, 32'h0000_0013);
        checkOutput("first_instr_pc", sIpc, 32'h0);
        applyStimulus();
        checkOutput("second_instr", sInstr, 32'h0050_0093);
        checkOutput("second_instr_pc", sIpc, 32'h4);

        $display("[TB] backpressure from decode and memory");
        doReset();
        instr_ready = 1'b0;
        fireCount = 0;
        repeat (8) applyStimulus();
        checkOutput("full_fire_count", fireCount, 2);
        checkOutput("full_req_valid", 32'(sReqValid), 32'h0);
        instr_ready = 1'b1;
        applyStimulus();
        instr_ready = 1'b0;
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkOutput("stall_req_valid", 32'(sReqValid), 32'h1);
            checkOutput("stall_req_addr", sAddr, 32'h8);
        end
        imem_req_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("post_stall_addr", sAddr, 32'hC);

        $display("[TB] redirect with two in flight");
        setupTwoInFlight();
        checkOutput("drain_no_req", 32'(sReqValid), 32'h0);
        checkOutput("drain_flushed", 32'(sIvalid), 32'h0);
        memHold = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus();
            if (sReqValid) found = 1;
        end
        checkOutput("drain_exit_seen", 32'(found), 32'h1);
        checkOutput("drain_exit_addr", sAddr, 32'h8);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus();
            if (sIvalid) found = 1;
        end
        checkOutput("redirect_instr_seen", 32'(found), 32'h1);
        checkOutput("redirect_instr_pc", sIpc, 32'h8);
        checkOutput("redirect_instr", sInstr, memWord(32'h8));

        $display("[TB] redirect target table");
        for (int v = 0; v < 5; v++) begin
            imem_req_ready = 1'b1;
            instr_ready = 1'b0;
            repeat (8) applyStimulus();
            imem_req_ready = 1'b0;
            PCSrc = 1'b1;
            branch_pc = vecs[v].bpc;
            ImmExt = vecs[v].imm;
            applyStimulus();
            PCSrc = 1'b0;
            imem_req_ready = 1'b1;
            applyStimulus();
            checkOutput("vec_req_valid", 32'(sReqValid), 32'h1);
            checkOutput("vec_target", sAddr, vecs[v].expAddr);
            checkOutput("vec_flushed", 32'(sIvalid), 32'h0);
        end

        $display("[TB] reset in the middle of a drain");
        setupTwoInFlight();
        doReset();
        imem_req_ready = 1'b1;
        applyStimulus();
        checkOutput("rearm_boot_no_req", 32'(sReqValid), 32'h0);
        applyStimulus();
        checkOutput("rearm_addr", sAddr, 32'h0);

        $display("[TB] randomized run");
        randLat = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset();
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            memHold = ($urandom_range(0, 7) == 0);
            PCSrc = ($urandom_range(0, 11) == 0);
            branch_pc = $urandom;
            r = $urandom;
            ImmExt = $urandom_range(0, 1) ? $urandom : {{24{r[7]}}, r[7:0]};
            applyStimulus();
        end
        PCSrc = 1'b0;
        memHold = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. Produces the instruction word consumed by the decode stage, and consumes the decode/execute outputs PCSrc and ImmExt to redirect the PC.
- Issues in-order requests to instruction memory over a valid/ready request channel and a response channel with no backpressure.
- Buffers returned words in a small FIFO.
- Presents {instr, instr_pc} to decode with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, instruction width.
- ADDR_WIDTH, 32, PC/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 2, prefetch buffer entries; also the cap on in-flight plus buffered instructions (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  ADDR_WIDTH  word-aligned fetch address.
- imem_rsp_valid  in  1  response word valid; always accepted, returned in order.
- imem_rsp_data  in  DATA_WIDTH  returned instruction.
- instr_valid  out  1  instr/instr_pc valid toward decode.
- instr_ready  in  1  decode consumes the instruction.
- instr  out  DATA_WIDTH  instruction to decode.
- instr_pc  out  ADDR_WIDTH  PC of instr.
- PCSrc  in  1  redirect request (taken branch/jump).
- ImmExt  in  DATA_WIDTH  sign-extended offset.
- branch_pc  in  ADDR_WIDTH  PC of the redirecting instruction.

Behaviour:
- Reset (async, on rst_n=0): state=BOOT, pc_q=RESET_PC, rsp_pc_q=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=0.
- States:
  - BOOT: no requests; moves to FETCH unconditionally after one cycle.
  - FETCH: normal operation.
  - DRAIN: discard stale in-flight responses after a redirect.
- FETCH request rules:
  - imem_req_valid=1 when outstanding+fifo_count < FIFO_DEPTH; imem_req_addr=pc_q.
  - On valid&ready: pc_q += 4 (wraps mod 2^ADDR_WIDTH) and outstanding increments.
  - While valid&!ready, addr and valid are held stable. The only exception is the redirect cycle.
- Responses:
  - In FETCH, each rsp_valid pushes {imem_rsp_data, rsp_pc_q}, then rsp_pc_q += 4 and outstanding decrements.
  - The credit rule guarantees FIFO space, so overflow is impossible. Reaching overflow is an assertion failure.
- Output to decode:
  - instr_valid = FIFO non-empty; instr and instr_pc come from the FIFO head.
  - A pop happens on instr_valid&instr_ready.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
  - Latency from rsp_valid to instr_valid is 1 cycle. Sustained throughput is 1 instruction/cycle with zero-latency memory.
- Redirect (PCSrc=1) has the highest priority, in any state except BOOT, where it is ignored.
  - target = (branch_pc + ImmExt) truncated to ADDR_WIDTH, with bits [1:0] forced to 0.
  - Same cycle: any pop completes (decode owns squashing). The FIFO is flushed at the edge; a response arriving in this cycle is dropped.
  - pc_q and rsp_pc_q are set to target.
  - drop_cnt = outstanding + (request accepted this cycle) − (rsp_valid this cycle).
  - Next state is DRAIN if drop_cnt > 0, else FETCH.
- DRAIN:
  - imem_req_valid=0.
  - Each rsp_valid decrements drop_cnt and outstanding, and nothing is pushed.
  - On the response that takes drop_cnt to 0, go to FETCH; requests resume the next cycle.
  - PCSrc in DRAIN updates pc_q and rsp_pc_q to the new target and leaves drop_cnt unchanged.
- Simultaneous redirect and request handshake: the accepted request counts as stale. The address changes the next cycle.
- Reset asserted mid-operation discards all FIFO contents and counters immediately. The memory side is reset on the same rst_n.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetched (32) and perf_redirects (32), both reset to 0.
  - perf_fetched increments on each pop.
  - perf_redirects increments on each accepted PCSrc.
  - Both wrap at 2^32.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {BOOT, FETCH, DRAIN}.
  - INSTR_NOP = 32'h0000_0013.
  - PC_STEP = 4.
  - fetch_entry_t struct {data, pc}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH parameter, push/pop/flush, count/empty/full, and same-cycle push+pop at full.

Test Plan:
- Reset release with ready=1 and 1-cycle memory -> first request addr 0x0 in the cycle after BOOT; instr 0x00000013/0x00500093 appear with instr_pc 0x0/0x4 on consecutive cycles.
- instr_ready=0 held -> exactly 2 requests issued (0x0, 0x4), FIFO full, imem_req_valid=0; instr_ready=1 for one cycle -> next request 0x8 issued.
- imem_req_ready=0 for 3 cycles -> imem_req_addr held at 0x8 and valid held; no pc advance.
- PCSrc=1, branch_pc=0x10, ImmExt=0xFFFFFFF8 with 2 in flight -> FIFO flushed, DRAIN drops 2 responses, next request addr 0x8, next instr_pc 0x8.
- PCSrc with branch_pc=0x100, ImmExt=0x6 -> target 0x104, low bits cleared; with nothing in flight -> FETCH directly, request 0x104 the next cycle.
- rst_n low mid-DRAIN -> all outputs return to reset values asynchronously; after release, fetch restarts at RESET_PC.
